// File: rtl/cla_pkg.sv
// Shared types and default sizing for the pipelined carry-lookahead adder.
package cla_pkg;

    typedef enum logic {
        OP_ADD,
        OP_SUB
    } op_e;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_BLK_W = 4;

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result stream bundle for the pipelined CLA adder.
// master drives operands and consumes results; slave is the adder.
interface pipelined_cla_adder_if
    import cla_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, carry, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, carry, ovf
    );
endinterface

// File: rtl/cla_block.sv
// One BLK_W-bit carry-lookahead group: generate/propagate with flat carry terms.
module cla_block #(
    parameter int BLK_W = 4
) (
    input  logic [BLK_W-1:0] a,
    input  logic [BLK_W-1:0] b,
    input  logic             ci,
    output logic [BLK_W-1:0] s,
    output logic             co,
    output logic             c_msb_in
);
    logic [BLK_W-1:0] g;
    logic [BLK_W-1:0] p;
    logic [BLK_W:0]   c;
    logic             acc;
    logic             run_p;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is the OR over j of g[j] gated by the propagates above j, plus ci gated by all
    // propagates below it, so no carry depends on another carry inside the group.
    always_comb begin
        c     = '0;
        acc   = 1'b0;
        run_p = 1'b1;
        c[0]  = ci;
        for (int i = 0; i < BLK_W; i++) begin
            acc   = 1'b0;
            run_p = 1'b1;
            for (int j = i; j >= 0; j--) begin
                acc   = acc | (g[j] & run_p);
                run_p = run_p & p[j];
            end
            c[i+1] = acc | (ci & run_p);
        end
    end

    assign s        = p ^ c[BLK_W-1:0];
    assign co       = c[BLK_W];
    assign c_msb_in = c[BLK_W-1];
endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor. One lookahead group is resolved per stage;
// the group carry is registered between stages and the untouched upper operand bits travel
// along with the partial sum. Valid/ready with a combinational ready chain so bubbles collapse.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int BLK_W = DEFAULT_BLK_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_cla_adder_if.slave bus
);
    localparam int NSTG = WIDTH / BLK_W;

    if ((WIDTH % BLK_W) != 0) begin : g_bad_width
        $error("pipelined_cla_adder: WIDTH must be a multiple of BLK_W");
    end

    op_e              op;

    // stage registers: stage k holds the operands/carry needed to resolve group k
    logic [NSTG-1:0]  v;
    logic [WIDTH-1:0] a_r   [NSTG];
    logic [WIDTH-1:0] b_r   [NSTG];
    logic [WIDTH-1:0] s_r   [NSTG];
    logic             c_r   [NSTG];

    // values offered to each stage register on advance
    logic [NSTG-1:0]  v_in;
    logic [WIDTH-1:0] a_in  [NSTG];
    logic [WIDTH-1:0] b_in  [NSTG];
    logic [WIDTH-1:0] s_in  [NSTG];
    logic             c_in  [NSTG];

    // per-group lookahead results and the partial sum with group k filled in
    logic [BLK_W-1:0] blk_s  [NSTG];
    logic             blk_co [NSTG];
    logic             blk_cm [NSTG];
    logic [WIDTH-1:0] s_nx   [NSTG];

    // adv[k]: stage k may load this cycle; adv[NSTG] belongs to the output register
    logic [NSTG:0]    adv;

    logic             out_valid_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             ovf_r;

    assign op = bus.sub ? OP_SUB : OP_ADD;

    // Ready chain from the output back to the input: a stage moves if it is empty or its successor moves.
    always_comb begin
        adv       = '0;
        adv[NSTG] = !out_valid_r || bus.out_ready;
        for (int k = NSTG - 1; k >= 0; k--) begin
            adv[k] = !v[k] || adv[k+1];
        end
    end

    // Stage inputs: stage 0 captures the bus (b inverted and carry forced for subtract), later stages take their predecessor.
    always_comb begin
        v_in    = '0;
        v_in[0] = bus.in_valid;
        a_in[0] = bus.a;
        b_in[0] = (op == OP_SUB) ? ~bus.b : bus.b;
        c_in[0] = (op == OP_SUB) ? 1'b1 : bus.cin;
        s_in[0] = '0;
        for (int k = 1; k < NSTG; k++) begin
            v_in[k] = v[k-1];
            a_in[k] = a_r[k-1];
            b_in[k] = b_r[k-1];
            c_in[k] = blk_co[k-1];
            s_in[k] = s_nx[k-1];
        end
    end

    // Merge each group's sum bits into the partial sum carried by that stage.
    always_comb begin
        for (int k = 0; k < NSTG; k++) begin
            s_nx[k]                    = s_r[k];
            s_nx[k][k*BLK_W +: BLK_W] = blk_s[k];
        end
    end

    for (genvar k = 0; k < NSTG; k++) begin : g_grp
        cla_block #(
            .BLK_W (BLK_W)
        ) u_blk (
            .a        (a_r[k][k*BLK_W +: BLK_W]),
            .b        (b_r[k][k*BLK_W +: BLK_W]),
            .ci       (c_r[k]),
            .s        (blk_s[k]),
            .co       (blk_co[k]),
            .c_msb_in (blk_cm[k])
        );
    end

    // Stage valid bits: the only state that must be cleared so in-flight beats vanish on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
        end else begin
            for (int k = 0; k < NSTG; k++) begin
                if (adv[k]) begin
                    v[k] <= v_in[k];
                end
            end
        end
    end

    // Stage data: loaded only when a real beat moves in, otherwise left alone.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NSTG; k++) begin
            if (adv[k] && v_in[k]) begin
                a_r[k] <= a_in[k];
                b_r[k] <= b_in[k];
                c_r[k] <= c_in[k];
                s_r[k] <= s_in[k];
            end
        end
    end

    // Output register: resolves the top group and holds the result until it is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            sum_r       <= '0;
            carry_r     <= 1'b0;
            ovf_r       <= 1'b0;
        end else if (adv[NSTG]) begin
            out_valid_r <= v[NSTG-1];
            if (v[NSTG-1]) begin
                sum_r   <= s_nx[NSTG-1];
                carry_r <= blk_co[NSTG-1];
                ovf_r   <= blk_co[NSTG-1] ^ blk_cm[NSTG-1];
            end
        end
    end

    assign bus.in_ready  = adv[0];
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.carry     = carry_r;
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed cases on a 16/4 instance, then concurrent random
// streams on 16/4, 8/2 and 32/8 instances against an arithmetic reference model.
module tb_pipelined_cla_adder;

    typedef struct packed {
        logic        ovf;
        logic        carry;
        logic [31:0] sum;
    } res_t;

    logic       clk;
    logic       rst_n;
    logic       start_rand = 1'b0;
    logic [2:0] rand_done;
    int         n_checks = 0;
    int         n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipelined_cla_adder_if #(.WIDTH(16)) bus0 ();

    pipelined_cla_adder #(
        .WIDTH (16),
        .BLK_W (4)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Plain integer arithmetic: unsigned result/carry and a signed range test for overflow.
    function automatic res_t ref_model(input int w, input longint unsigned a, input longint unsigned b,
                                       input logic cin, input logic sub);
        res_t              r;
        longint unsigned   span;
        longint            half, sa, sb, sr;
        span = 64'd1 << w;
        half = longint'(span >> 1);
        sa   = (longint'(a) >= half) ? longint'(a) - longint'(span) : longint'(a);
        sb   = (longint'(b) >= half) ? longint'(b) - longint'(span) : longint'(b);
        if (sub) begin
            r.sum   = 32'((a + span - b) % span);
            r.carry = (a >= b);
            sr      = sa - sb;
        end else begin
            r.sum   = 32'((a + b + 64'(cin)) % span);
            r.carry = ((a + b + 64'(cin)) >= span);
            sr      = sa + sb + longint'(cin);
        end
        r.ovf = (sr >= half) || (sr < -half);
        return r;
    endfunction

    task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic sub,
                           input logic [15:0] esum, input logic ec, input logic eo);
        int lat;
        @(posedge clk); #1;
        bus0.in_valid  = 1'b1;
        bus0.a         = a;
        bus0.b         = b;
        bus0.cin       = cin;
        bus0.sub       = sub;
        bus0.out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 64'(bus0.in_ready), 64'd1);
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        lat = 0;
        while (!bus0.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_sum"},     64'(bus0.sum),   64'(esum));
        check({tag, "_carry"},   64'(bus0.carry), 64'(ec));
        check({tag, "_ovf"},     64'(bus0.ovf),   64'(eo));
    endtask

    // Random streams, one per parameter set, all started together.
    for (genvar gi = 0; gi < 3; gi++) begin : g_rand
        localparam int W = (gi == 0) ? 16 : (gi == 1) ? 8 : 32;
        localparam int B = (gi == 0) ? 4  : (gi == 1) ? 2 : 8;

        logic done_f = 1'b0;
        assign rand_done[gi] = done_f;

        pipelined_cla_adder_if #(.WIDTH(W)) bus ();

        pipelined_cla_adder #(
            .WIDTH (W),
            .BLK_W (B)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        initial begin
            res_t q[$];
            res_t e;
            int   sent;
            int   got;
            logic fire_in;
            logic fire_out;
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b0;
            bus.a         = '0;
            bus.b         = '0;
            bus.cin       = 1'b0;
            bus.sub       = 1'b0;
            sent = 0;
            got  = 0;
            wait (start_rand === 1'b1);
            for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
                @(posedge clk); #1;
                bus.in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
                bus.a         = W'($urandom);
                bus.b         = W'($urandom);
                bus.cin       = 1'($urandom_range(0, 1));
                bus.sub       = 1'($urandom_range(0, 1));
                bus.out_ready = ($urandom_range(0, 3) != 0);
                #1;
                fire_in  = bus.in_valid && bus.in_ready;
                fire_out = bus.out_valid && bus.out_ready;
                if (fire_in) begin
                    q.push_back(ref_model(W, 64'(bus.a), 64'(bus.b), bus.cin, bus.sub));
                    sent++;
                end
                if (fire_out) begin
                    check($sformatf("w%0d_has_expected", W), 64'(q.size() != 0), 64'd1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        check($sformatf("w%0d_result", W),
                              64'({bus.ovf, bus.carry, bus.sum}),
                              64'({e.ovf, e.carry, e.sum[W-1:0]}));
                    end
                    got++;
                end
            end
            bus.in_valid = 1'b0;
            check($sformatf("w%0d_delivered", W), 64'(got), 64'd1000);
            check($sformatf("w%0d_scoreboard_empty", W), 64'(q.size()), 64'd0);
            done_f = 1'b1;
        end
    end

    initial begin
        res_t        q4[$];
        res_t        e;
        int          sent;
        int          got;
        int          stall_left;
        int          seen;
        logic [17:0] held;
        logic        fire_in;
        logic        fire_out;

        rst_n          = 1'b0;
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;
        bus0.a         = '0;
        bus0.b         = '0;
        bus0.cin       = 1'b0;
        bus0.sub       = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_out_valid", 64'(bus0.out_valid), 64'd0);
        check("rst_sum",       64'(bus0.sum),       64'd0);
        check("rst_carry",     64'(bus0.carry),     64'd0);
        check("rst_ovf",       64'(bus0.ovf),       64'd0);
        check("rst_in_ready",  64'(bus0.in_ready),  64'd1);

        // wrap, signed overflow on subtract and on add
        run_one("wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_one("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_one("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

        // back-to-back 8 beats with a 6-cycle output stall after the first result
        sent = 0;
        got = 0;
        stall_left = 0;
        seen = 0;
        held = '0;
        for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
            @(posedge clk); #1;
            bus0.in_valid = (sent < 8);
            bus0.a        = 16'h1111 * 16'(sent + 1);
            bus0.b        = 16'h0F0F + 16'(sent);
            bus0.cin      = sent[0];
            bus0.sub      = 1'b0;
            if (seen == 0 && bus0.out_valid) begin
                seen       = 1;
                stall_left = 6;
                held       = {bus0.ovf, bus0.carry, bus0.sum};
            end
            bus0.out_ready = (stall_left == 0);
            #1;
            if (stall_left > 0) begin
                check("stall_out_valid", 64'(bus0.out_valid), 64'd1);
                check("stall_hold", 64'({bus0.ovf, bus0.carry, bus0.sum}), 64'(held));
                if (stall_left == 1) begin
                    check("stall_in_ready", 64'(bus0.in_ready), 64'd0);
                    check("stall_accepted", 64'(sent), 64'd5);
                end
            end
            fire_in  = bus0.in_valid && bus0.in_ready;
            fire_out = bus0.out_valid && bus0.out_ready;
            if (fire_in) begin
                q4.push_back(ref_model(16, 64'(bus0.a), 64'(bus0.b), bus0.cin, 1'b0));
                sent++;
            end
            if (fire_out) begin
                check("b2b_has_expected", 64'(q4.size() != 0), 64'd1);
                if (q4.size() != 0) begin
                    e = q4.pop_front();
                    check("b2b_result", 64'({bus0.ovf, bus0.carry, bus0.sum}),
                          64'({e.ovf, e.carry, e.sum[15:0]}));
                end
                got++;
            end
            if (stall_left > 0) stall_left--;
        end
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;
        check("b2b_delivered", 64'(got), 64'd8);
        check("b2b_scoreboard_empty", 64'(q4.size()), 64'd0);

        // reset with three beats in flight, first result waiting at the output
        @(posedge clk); #1;
        bus0.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus0.in_valid = 1'b1;
            bus0.a        = 16'h1234 + 16'(i);
            bus0.b        = 16'h1111;
            bus0.cin      = 1'b0;
            bus0.sub      = 1'b0;
            @(posedge clk); #1;
        end
        bus0.in_valid = 1'b0;
        for (int i = 0; i < 10 && !bus0.out_valid; i++) begin
            @(posedge clk); #1;
        end
        check("rst_mid_pre_valid", 64'(bus0.out_valid), 64'd1);
        check("rst_mid_pre_sum",   64'(bus0.sum),       64'h2345);
        #3 rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 64'(bus0.out_valid), 64'd0);
        check("rst_mid_sum",       64'(bus0.sum),       64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n          = 1'b1;
        bus0.out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus0.out_valid) seen++;
        end
        check("rst_mid_no_ghosts", 64'(seen), 64'd0);
        check("rst_mid_in_ready",  64'(bus0.in_ready), 64'd1);

        // random streams on all three parameter sets
        start_rand = 1'b1;
        for (int c = 0; c < 40000 && rand_done != 3'b111; c++) @(posedge clk);
        check("rand_all_done", 64'(rand_done), 64'h7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
